xillybus_fifo_bank: RTL

Parametrised bank of NCHAN bidirectional stream channels between the Xillybus core's per-channel FIFO ports and fabric user logic, one synchronous FIFO per direction per channel. It supersedes hand-instantiated per-stream FIFOs around the core. It adds:
- configurable width and depth
- flush-on-close
- a user-driven end-of-file handshake
- per-channel fill-level status

It sits directly beside the core on bus_clk; host-side ports connect 1:1 to the core's user_w_*/user_r_* signals.

---
 rtl/xillybus_fifo_bank_pkg.sv | 16 +
 rtl/xillybus_sync_fifo.sv | 86 ++++++++
 rtl/xillybus_fifo_bank.sv | 101 ++++++++++
 3 files changed

// File: rtl/xillybus_fifo_bank_pkg.sv
// Shared types for the Xillybus FIFO bank: the per-channel EOF state and
// the width of a FIFO occupancy count.
package xillybus_fifo_bank_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    SIGNALLED = 2'd2
  } eof_state_t;

  // An occupancy of 0..depth needs one bit more than a pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xillybus_sync_fifo.sv
// Single-clock FIFO with flush, exact occupancy count, and either
// first-word-fall-through or registered-read output.
module xillybus_sync_fifo
  import xillybus_fifo_bank_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 512,
  parameter bit FWFT  = 1'b1
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          push_ok, pop_ok;

  // Full/empty come from the registered count, so a push is refused while
  // full even if a pop happens in the same cycle.
  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign level   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem[rd_ptr_q];
      end
      count_d = count_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout = mem[rd_ptr_q];
    end else begin : g_reg
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: rtl/xillybus_fifo_bank.sv
// Bank of independent bidirectional stream channels beside the Xillybus core:
// one FIFO per direction per channel, flush-on-close and an EOF handshake.
module xillybus_fifo_bank
  import xillybus_fifo_bank_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    bus_clk,
  input  logic                    bus_rst,
  input  logic [NCHAN-1:0]        w_open,
  input  logic [NCHAN-1:0]        w_wren,
  input  logic [NCHAN*DW-1:0]     w_data,
  output logic [NCHAN-1:0]        w_full,
  output logic [NCHAN-1:0]        u_rx_valid,
  output logic [NCHAN*DW-1:0]     u_rx_data,
  input  logic [NCHAN-1:0]        u_rx_ready,
  input  logic [NCHAN-1:0]        r_open,
  input  logic [NCHAN-1:0]        r_rden,
  output logic [NCHAN*DW-1:0]     r_data,
  output logic [NCHAN-1:0]        r_empty,
  output logic [NCHAN-1:0]        r_eof,
  input  logic [NCHAN-1:0]        u_tx_valid,
  input  logic [NCHAN*DW-1:0]     u_tx_data,
  output logic [NCHAN-1:0]        u_tx_ready,
  input  logic [NCHAN-1:0]        u_tx_eof,
  output logic [NCHAN*(AW+1)-1:0] rx_level,
  output logic [NCHAN*(AW+1)-1:0] tx_level
);

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic       w_open_q, w_open_d;
    logic       r_open_q, r_open_d;
    eof_state_t eof_q, eof_d;
    logic       w_fall, r_fall;
    logic       rx_empty, tx_full, tx_empty, tx_push;

    assign w_fall  = w_open_q && !w_open[c];
    assign r_fall  = r_open_q && !r_open[c];
    // The registered r_open keeps the user side closed until a cycle after reset.
    assign u_tx_ready[c] = !tx_full && (eof_q == IDLE) && r_open_q;
    assign tx_push       = u_tx_valid[c] && u_tx_ready[c];
    assign u_rx_valid[c] = !rx_empty;
    assign r_empty[c]    = tx_empty;
    assign r_eof[c]      = (eof_q == SIGNALLED) && tx_empty;

    always_comb begin
      w_open_d = w_open[c];
      r_open_d = r_open[c];
      eof_d    = eof_q;
      unique case (eof_q)
        IDLE:      if (u_tx_eof[c] && r_open_q) eof_d = PENDING;
        PENDING:   if (tx_empty) eof_d = SIGNALLED;
        SIGNALLED: eof_d = SIGNALLED;
        default:   eof_d = IDLE;
      endcase
      if (r_fall) eof_d = IDLE;
    end

    always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
        w_open_q <= 1'b0;
        r_open_q <= 1'b0;
        eof_q    <= IDLE;
      end else begin
        w_open_q <= w_open_d;
        r_open_q <= r_open_d;
        eof_q    <= eof_d;
      end
    end

    xillybus_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_rx_fifo (
      .bus_clk (bus_clk),
      .bus_rst (bus_rst),
      .flush   (w_fall),
      .push    (w_wren[c]),
      .din     (w_data[c*DW +: DW]),
      .pop     (u_rx_ready[c]),
      .dout    (u_rx_data[c*DW +: DW]),
      .full    (w_full[c]),
      .empty   (rx_empty),
      .level   (rx_level[c*(AW+1) +: (AW+1)])
    );

    xillybus_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_tx_fifo (
      .bus_clk (bus_clk),
      .bus_rst (bus_rst),
      .flush   (r_fall),
      .push    (tx_push),
      .din     (u_tx_data[c*DW +: DW]),
      .pop     (r_rden[c]),
      .dout    (r_data[c*DW +: DW]),
      .full    (tx_full),
      .empty   (tx_empty),
      .level   (tx_level[c*(AW+1) +: (AW+1)])
    );
  end

endmodule
